// File: rtl/pwm_breather.sv
// Multi-channel LED breathing PWM with exponential/linear duty ramps.
// Define PWM_BREATHER_ACTIVE_LOW_EN for sink-driven (active-low) LEDs.
module pwm_breather #(
   parameter int CHANNELS   = 4,
   parameter int DUTY_BITS  = 8,
   parameter int PRESC_BITS = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  en,
   input  logic                  mode,
   input  logic [PRESC_BITS-1:0] step_period,
   output logic [CHANNELS-1:0]   led,
   output logic                  cycle_done
);

`ifdef PWM_BREATHER_ACTIVE_LOW_EN
   localparam logic POL = 1'b1;
`else
   localparam logic POL = 1'b0;
`endif

   localparam logic [DUTY_BITS-1:0] DMAX = '1;

   typedef enum logic {DOWN = 1'b0, UP = 1'b1} dir_t;

   logic [DUTY_BITS-1:0]  pcnt;
   logic [PRESC_BITS-1:0] presc;
   logic                  tick;
   logic                  turn0;
   logic [CHANNELS-1:0]   raw;
   logic [DUTY_BITS-1:0]  duty     [CHANNELS];
   logic [DUTY_BITS-1:0]  duty_nxt [CHANNELS];
   dir_t                  dir      [CHANNELS];
   dir_t                  dir_nxt  [CHANNELS];

   // Staggered start: channel i begins at 2^(i mod (DUTY_BITS+1)) - 1.
   function automatic logic [DUTY_BITS-1:0] rst_duty(input int i);
      int s;
      s = i % (DUTY_BITS + 1);
      return DUTY_BITS'((64'd1 << s) - 64'd1);
   endfunction

   function automatic logic [DUTY_BITS-1:0] up_step(
      input logic [DUTY_BITS-1:0] d,
      input logic                 lin
   );
      if (lin) return d + DUTY_BITS'(1);
      if (d[DUTY_BITS-1]) return DMAX;
      return {d[DUTY_BITS-2:0], 1'b1};
   endfunction

   function automatic logic [DUTY_BITS-1:0] down_step(
      input logic [DUTY_BITS-1:0] d,
      input logic                 lin
   );
      if (lin) return d - DUTY_BITS'(1);
      return d >> 1;
   endfunction

   always_comb begin
      tick  = en && (presc >= step_period);
      turn0 = tick && (dir[0] == DOWN) && (duty[0] == '0);
      raw   = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         duty_nxt[i] = duty[i];
         dir_nxt[i]  = dir[i];
         raw[i]      = pcnt < duty[i];
         if (tick) begin
            unique case (1'b1)
               (dir[i] == UP) && (duty[i] == DMAX): begin
                  dir_nxt[i]  = DOWN;
                  duty_nxt[i] = down_step(duty[i], mode);
               end
               (dir[i] == DOWN) && (duty[i] == '0): begin
                  dir_nxt[i]  = UP;
                  duty_nxt[i] = up_step(duty[i], mode);
               end
               (dir[i] == UP) && (duty[i] != DMAX):
                  duty_nxt[i] = up_step(duty[i], mode);
               default:
                  duty_nxt[i] = down_step(duty[i], mode);
            endcase
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pcnt       <= '0;
         presc      <= '0;
         cycle_done <= 1'b0;
         led        <= {CHANNELS{POL}};
         for (int i = 0; i < CHANNELS; i++) begin
            duty[i] <= rst_duty(i);
            dir[i]  <= UP;
         end
      end else begin
         pcnt       <= pcnt + DUTY_BITS'(1);
         cycle_done <= turn0;
         led        <= raw ^ {CHANNELS{POL}};
         if (tick) presc <= '0;
         else if (en) presc <= presc + PRESC_BITS'(1);
         for (int i = 0; i < CHANNELS; i++) begin
            duty[i] <= duty_nxt[i];
            dir[i]  <= dir_nxt[i];
         end
      end
   end

endmodule

// File: tb/tb_pwm_breather.sv
// Scoreboard bench for pwm_breather: random stimulus vs. arithmetic model.
// Honours PWM_BREATHER_ACTIVE_LOW_EN for the expected LED polarity.
module tb_pwm_breather;
   localparam int CH   = 6;
   localparam int DB   = 4;
   localparam int PB   = 4;
   localparam int MAXD = (1 << DB) - 1;
   localparam int HALF = 1 << (DB - 1);

`ifdef PWM_BREATHER_ACTIVE_LOW_EN
   localparam bit AL = 1'b1;
`else
   localparam bit AL = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          en = 1'b0;
   logic          mode = 1'b0;
   logic [PB-1:0] step_period = '0;
   logic [CH-1:0] led;
   logic          cycle_done;

   int total = 0;
   int bad = 0;

   int m_duty [CH];
   bit m_dir  [CH];
   int m_pcnt = 0;
   int m_presc = 0;

   logic [CH:0] exp_q [$];
   logic [CH:0] want;
   int act_cnt = 0;
   int cd_cnt = 0;
   int cyc = 0;
   int cd_last = -1;
   int cd_prev = -1;

   pwm_breather #(
      .CHANNELS(CH),
      .DUTY_BITS(DB),
      .PRESC_BITS(PB)
   ) dut (
      .clk(clk),
      .rst(rst),
      .en(en),
      .mode(mode),
      .step_period(step_period),
      .led(led),
      .cycle_done(cycle_done)
   );

   always #5 clk = ~clk;

   function automatic int go_up(input int d, input bit lin);
      if (lin) return d + 1;
      if (d >= HALF) return MAXD;
      return 2 * d + 1;
   endfunction

   function automatic int go_down(input int d, input bit lin);
      if (lin) return d - 1;
      return d / 2;
   endfunction

   // Expected outputs after the coming edge, then advance the model.
   task automatic model_step();
      logic [CH-1:0] e_led;
      bit e_cd;
      bit tk;
      e_cd = 1'b0;
      if (rst) begin
         e_led = AL ? '1 : '0;
         m_pcnt = 0;
         m_presc = 0;
         for (int i = 0; i < CH; i++) begin
            m_duty[i] = (2 ** (i % (DB + 1))) - 1;
            m_dir[i] = 1'b1;
         end
      end else begin
         for (int i = 0; i < CH; i++)
            e_led[i] = (m_pcnt < m_duty[i]) ^ AL;
         tk = en && (m_presc >= int'(step_period));
         if (tk) begin
            for (int i = 0; i < CH; i++) begin
               if (m_dir[i] && m_duty[i] == MAXD) begin
                  m_dir[i] = 1'b0;
               end else if (!m_dir[i] && m_duty[i] == 0) begin
                  m_dir[i] = 1'b1;
                  if (i == 0) e_cd = 1'b1;
               end
               m_duty[i] = m_dir[i] ? go_up(m_duty[i], mode)
                                    : go_down(m_duty[i], mode);
            end
            m_presc = 0;
         end else if (en) begin
            m_presc = m_presc + 1;
         end
         m_pcnt = (m_pcnt + 1) % (MAXD + 1);
      end
      exp_q.push_back({e_cd, e_led});
   endtask

   task automatic drive(input bit r, input bit e, input bit m, input int sp);
      @(negedge clk);
      rst = r;
      en = e;
      mode = m;
      step_period = PB'(sp);
      model_step();
   endtask

   task automatic settle();
      @(posedge clk);
      #2;
   endtask

   task automatic check(input string name, input int got, input int exp_v);
      total++;
      if (got != exp_v) begin
         bad++;
         $display("FAIL %s got=%0d want=%0d", name, got, exp_v);
      end
   endtask

   task automatic freeze_count(input string name, input int exp_v);
      int c0;
      repeat (4) drive(0, 0, 0, 0);
      settle();
      c0 = act_cnt;
      repeat (16) drive(0, 0, 0, 0);
      settle();
      check(name, act_cnt - c0, exp_v);
   endtask

   always @(posedge clk) begin
      #1;
      if (exp_q.size() > 0) begin
         want = exp_q.pop_front();
         total++;
         if ({cycle_done, led} !== want) begin
            bad++;
            $display("FAIL scoreboard cyc=%0d got cd=%b led=%b want cd=%b led=%b",
                     cyc, cycle_done, led, want[CH], want[CH-1:0]);
         end
         cyc++;
         if (led[0] == !AL) act_cnt++;
         if (cycle_done === 1'b1) begin
            cd_cnt++;
            cd_prev = cd_last;
            cd_last = cyc;
         end
      end
   end

   initial begin
      int c0;
      bit rm;
      int rs;

      // Exponential ramp with PWM frozen at chosen duties.
      repeat (3) drive(1, 0, 0, 0);
      repeat (2) drive(0, 1, 0, 0);
      freeze_count("pwm_duty3", 3);
      repeat (2) drive(0, 1, 0, 0);
      freeze_count("pwm_duty15", 15);
      repeat (4) drive(0, 1, 0, 0);
      freeze_count("pwm_duty0", 0);
      c0 = cd_cnt;
      drive(0, 1, 0, 0);
      repeat (3) drive(0, 0, 0, 0);
      settle();
      check("exp_turnaround_pulse", cd_cnt - c0, 1);

      // Linear breath period at step_period 0.
      c0 = cd_cnt;
      drive(1, 0, 1, 0);
      repeat (70) drive(0, 1, 1, 0);
      settle();
      check("lin_pulses", cd_cnt - c0, 2);
      check("lin_period", cd_last - cd_prev, 30);

      // step_period 4 with an en gap: 9th tick lands on enabled cycle 45.
      drive(1, 0, 0, 4);
      settle();
      c0 = cd_cnt;
      repeat (30) drive(0, 1, 0, 4);
      repeat (7) drive(0, 0, 0, 4);
      repeat (14) drive(0, 1, 0, 4);
      settle();
      check("presc_no_pulse_yet", cd_cnt - c0, 0);
      drive(0, 1, 0, 4);
      drive(0, 1, 0, 4);
      settle();
      check("presc_pulse", cd_cnt - c0, 1);

      // Lower step_period mid-count, then reset mid-ramp.
      drive(1, 0, 0, 6);
      repeat (4) drive(0, 1, 0, 6);
      drive(0, 1, 0, 1);
      repeat (6) drive(0, 1, 1, 1);
      drive(1, 1, 1, 0);
      repeat (5) drive(0, 0, 0, 0);

      // Linear up to 5 then exponential: 11, 15, turnaround to 7.
      drive(1, 0, 1, 0);
      repeat (5) drive(0, 1, 1, 0);
      repeat (3) drive(0, 1, 0, 0);
      freeze_count("mode_switch_duty7", 7);

      // Randomised run.
      rm = 1'b0;
      rs = 0;
      for (int n = 0; n < 3000; n++) begin
         if ($urandom_range(0, 49) == 0) rm = ~rm;
         if ($urandom_range(0, 39) == 0)
            rs = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 15)
                                             : $urandom_range(0, 3);
         drive($urandom_range(0, 299) == 0, $urandom_range(0, 9) != 0, rm, rs);
      end
      settle();
      check("queue_drained", exp_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
